// File: rtl/mem_access_unit_if.sv
// Pipeline-request and datamem signals of the MEM-stage access unit.
// master = pipeline + datamem side, slave = mem_access_unit.
interface mem_access_unit_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_uns;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          busy;
    logic          done;
    logic [DW-1:0] rdata;
    logic          exc;
    logic          MemRead;
    logic          MemWrite;
    logic [AW-1:0] Addr;
    logic [DW-1:0] Wdata;
    logic [DW-1:0] Rdata;

    modport master (
        output req, req_we, req_size, req_uns, req_addr, req_wdata, Rdata,
        input  busy, done, rdata, exc, MemRead, MemWrite, Addr, Wdata
    );

    modport slave (
        input  req, req_we, req_size, req_uns, req_addr, req_wdata, Rdata,
        output busy, done, rdata, exc, MemRead, MemWrite, Addr, Wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator for a word-only datamem; sub-word stores use read-modify-write.
// Optional macro MISALIGN_TRAP_EN: misaligned half/word requests complete at once with exc=1.
module mem_access_unit #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_unit_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        WR     = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t        state_q;
    logic          busy_q;
    logic          done_q;
    logic          exc_q;
    logic          mem_read_q;
    logic          mem_write_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [1:0]    off_q;
    logic [DW-1:0] sdata_q;
    logic          trap_s;

    // Bit position of the addressed lane inside the datamem word.
    function automatic logic [4:0] lane_shift(input logic [1:0] off, input logic [1:0] size);
        logic [4:0] sh;
        case (size)
            2'b00:   sh = BIG_ENDIAN ? {~off, 3'b000} : {off, 3'b000};
            2'b01:   sh = BIG_ENDIAN ? {~off[1], 4'b0000} : {off[1], 4'b0000};
            default: sh = 5'd0;
        endcase
        return sh;
    endfunction

    function automatic logic [DW-1:0] load_extend(input logic [DW-1:0] word, input logic [1:0] size,
                                                  input logic uns, input logic [1:0] off);
        logic [DW-1:0] v;
        logic [DW-1:0] r;
        v = word >> lane_shift(off, size);
        case (size)
            2'b00:   r = {{24{~uns & v[7]}}, v[7:0]};
            2'b01:   r = {{16{~uns & v[15]}}, v[15:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    function automatic logic [DW-1:0] merge_lane(input logic [DW-1:0] old, input logic [DW-1:0] data,
                                                 input logic [1:0] size, input logic [1:0] off);
        logic [DW-1:0] mask;
        logic [4:0]    sh;
        sh = lane_shift(off, size);
        case (size)
            2'b00:   mask = 32'h0000_00FF;
            2'b01:   mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        mask = mask << sh;
        return (old & ~mask) | ((data << sh) & mask);
    endfunction

    // Misalignment detection on the incoming request.
    always_comb begin
`ifdef MISALIGN_TRAP_EN
        trap_s = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                 (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`else
        trap_s = 1'b0;
`endif
    end

    // Access sequencer with registered datamem and pipeline outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            exc_q       <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            sdata_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    exc_q  <= 1'b0;
                    if (bus.req) begin
                        busy_q  <= 1'b1;
                        addr_q  <= {bus.req_addr[AW-1:2], 2'b00};
                        size_q  <= (bus.req_size == 2'b11) ? 2'b10 : bus.req_size;
                        uns_q   <= bus.req_uns;
                        off_q   <= bus.req_addr[1:0];
                        sdata_q <= bus.req_wdata;
                        if (trap_s) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            exc_q   <= 1'b1;
                            rdata_q <= '0;
                        end else if (!bus.req_we) begin
                            state_q    <= RD;
                            mem_read_q <= 1'b1;
                        end else if (!bus.req_size[1]) begin
                            state_q    <= RMW_RD;
                            mem_read_q <= 1'b1;
                        end else begin
                            state_q     <= WR;
                            mem_write_q <= 1'b1;
                            wdata_q     <= bus.req_wdata;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                RD: begin
                    mem_read_q <= 1'b0;
                    rdata_q    <= load_extend(bus.Rdata, size_q, uns_q, off_q);
                    done_q     <= 1'b1;
                    state_q    <= DONE;
                end
                WR: begin
                    mem_write_q <= 1'b0;
                    done_q      <= 1'b1;
                    state_q     <= DONE;
                end
                RMW_RD: begin
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b1;
                    wdata_q     <= merge_lane(bus.Rdata, sdata_q, size_q, off_q);
                    state_q     <= RMW_WR;
                end
                RMW_WR: begin
                    mem_write_q <= 1'b0;
                    done_q      <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    exc_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    exc_q       <= 1'b0;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.exc      = exc_q;
    assign bus.rdata    = rdata_q;
    assign bus.MemRead  = mem_read_q;
    assign bus.MemWrite = mem_write_q;
    assign bus.Addr     = addr_q;
    assign bus.Wdata    = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed + random bench for mem_access_unit against a byte-addressed big-endian memory model.
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    mem_access_unit_if bif ();

    mem_access_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    // datamem: combinational read, write on the clock edge
    bit [31:0] dmem [256];
    assign bif.Rdata = dmem[bif.Addr[9:2]];
    always @(posedge clk) if (bif.MemWrite) dmem[bif.Addr[9:2]] <= bif.Wdata;

    // reference: byte-addressed memory, byte 0 of a word is the most significant
    bit [7:0]  ref_b [1024];
    logic [31:0] exp_rdata = 32'h0;

    int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, acc_cnt = 0;
    logic prev_busy = 1'b0;
    logic [31:0] wd_seen = 32'h0, addr_seen = 32'h0;
    always @(negedge clk) begin
        if (bif.MemRead) begin rd_cnt++; addr_seen = bif.Addr; end
        if (bif.MemWrite) begin wr_cnt++; wd_seen = bif.Wdata; addr_seen = bif.Addr; end
        if (bif.MemRead && bif.MemWrite) both_cnt++;
        if (bif.busy && !prev_busy) acc_cnt++;
        prev_busy = bif.busy;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [9:0] a);
        logic [9:0] w;
        w = {a[9:2], 2'b00};
        return {ref_b[w], ref_b[w + 10'd1], ref_b[w + 10'd2], ref_b[w + 10'd3]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns, input logic [9:0] a);
        logic [9:0]  h;
        logic [15:0] v16;
        h = {a[9:1], 1'b0};
        v16 = {ref_b[h], ref_b[h + 10'd1]};
        if (size == 2'b00) return uns ? {24'h0, ref_b[a]} : {{24{ref_b[a][7]}}, ref_b[a]};
        if (size == 2'b01) return uns ? {16'h0, v16} : {{16{v16[15]}}, v16};
        return ref_word(a);
    endfunction

    task automatic ref_store(input logic [1:0] size, input logic [9:0] a, input logic [31:0] d);
        logic [9:0] h, w;
        h = {a[9:1], 1'b0};
        w = {a[9:2], 2'b00};
        if (size == 2'b00) ref_b[a] = d[7:0];
        else if (size == 2'b01) begin ref_b[h] = d[15:8]; ref_b[h + 10'd1] = d[7:0]; end
        else begin
            ref_b[w] = d[31:24]; ref_b[w + 10'd1] = d[23:16];
            ref_b[w + 10'd2] = d[15:8]; ref_b[w + 10'd3] = d[7:0];
        end
    endtask

    function automatic bit ref_trap(input logic [1:0] size, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
        return (size == 2'b01 && a[0]) || (size[1] && a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bif.req = 1'b1; bif.req_we = we; bif.req_size = size;
        bif.req_uns = uns; bif.req_addr = addr; bif.req_wdata = wdata;
    endtask

    task automatic do_op(input string tag, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int n, rd0, wr0, exp_lat, exp_rd, exp_wr;
        bit trap;
        trap = ref_trap(size, addr);
        if (trap) begin exp_lat = 1; exp_rd = 0; exp_wr = 0; end
        else if (!we) begin exp_lat = 2; exp_rd = 1; exp_wr = 0; end
        else if (size[1]) begin exp_lat = 2; exp_rd = 0; exp_wr = 1; end
        else begin exp_lat = 3; exp_rd = 1; exp_wr = 1; end
        @(negedge clk);
        rd0 = rd_cnt; wr0 = wr_cnt;
        drive(we, size, uns, addr, wdata);
        @(posedge clk); #1;
        bif.req = 1'b0;
        n = 1;
        while (!bif.done && n < 12) begin @(posedge clk); #1; n++; end
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_done"}, bif.done, 1'b1);
        chk({tag, "_busy"}, bif.busy, 1'b1);
        chk({tag, "_exc"}, bif.exc, trap);
        if (trap) exp_rdata = 32'h0;
        else if (we) ref_store(size, addr[9:0], wdata);
        else exp_rdata = ref_load(size, uns, addr[9:0]);
        chk({tag, "_rdata"}, bif.rdata, exp_rdata);
        chk({tag, "_rd_cycles"}, rd_cnt - rd0, exp_rd);
        chk({tag, "_wr_cycles"}, wr_cnt - wr0, exp_wr);
        if (we && !trap) chk({tag, "_wdata"}, wd_seen, ref_word(addr[9:0]));
        if (!trap) chk({tag, "_addr"}, addr_seen, {addr[31:2], 2'b00});
        @(posedge clk); #1;
        chk({tag, "_done_drop"}, bif.done, 1'b0);
        chk({tag, "_idle"}, bif.busy, 1'b0);
    endtask

    initial begin
        int n, dn, a0;
        logic [31:0] ra;
        bif.req = 1'b0; bif.req_we = 1'b0; bif.req_size = 2'b00;
        bif.req_uns = 1'b0; bif.req_addr = 32'h0; bif.req_wdata = 32'h0;
        #1;
        chk("reset_busy", bif.busy, 1'b0);
        chk("reset_done", bif.done, 1'b0);
        chk("reset_exc", bif.exc, 1'b0);
        chk("reset_memread", bif.MemRead, 1'b0);
        chk("reset_memwrite", bif.MemWrite, 1'b0);
        chk("reset_addr", bif.Addr, 32'h0);
        chk("reset_wdata", bif.Wdata, 32'h0);
        chk("reset_rdata", bif.rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // T1: reset while the RMW write is on the bus
        @(negedge clk);
        drive(1'b1, 2'b00, 1'b0, 32'h0010_0000, 32'h0000_00FF);
        @(posedge clk); #1;
        bif.req = 1'b0;
        n = 0;
        while (!bif.MemWrite && n < 10) begin @(posedge clk); #1; n++; end
        chk("T1_reach_write", bif.MemWrite, 1'b1);
        rst = 1'b1;
        #1;
        chk("T1_memwrite_drop", bif.MemWrite, 1'b0);
        chk("T1_busy", bif.busy, 1'b0);
        @(posedge clk); #1;
        chk("T1_word_kept", dmem[0], ref_word(10'h000));
        @(negedge clk);
        rst = 1'b0;

        do_op("T2_sw", 1'b1, 2'b10, 1'b0, 32'h0010_0000, 32'h1122_3344);
        do_op("T2_lw", 1'b0, 2'b10, 1'b0, 32'h0010_0000, 32'h0);
        chk("T2_const", bif.rdata, 32'h1122_3344);
        do_op("T3_sb", 1'b1, 2'b00, 1'b0, 32'h0010_0001, 32'h0000_00AA);
        chk("T3_const", wd_seen, 32'h11AA_3344);
        do_op("T4_lb", 1'b0, 2'b00, 1'b0, 32'h0010_0001, 32'h0);
        chk("T4_lb_const", bif.rdata, 32'hFFFF_FFAA);
        do_op("T4_lbu", 1'b0, 2'b00, 1'b1, 32'h0010_0001, 32'h0);
        chk("T4_lbu_const", bif.rdata, 32'h0000_00AA);
        do_op("T4_lhu", 1'b0, 2'b01, 1'b1, 32'h0010_0002, 32'h0);
        chk("T4_lhu_const", bif.rdata, 32'h0000_3344);
        do_op("T4_sh", 1'b1, 2'b01, 1'b0, 32'h0010_0002, 32'h0000_8001);
        do_op("T4_lh", 1'b0, 2'b01, 1'b0, 32'h0010_0002, 32'h0);
        chk("T4_lh_const", bif.rdata, 32'hFFFF_8001);

        do_op("T6_lw_mis", 1'b0, 2'b10, 1'b0, 32'h0010_0002, 32'h0);
`ifdef MISALIGN_TRAP_EN
        chk("T6_const", bif.rdata, 32'h0);
`else
        chk("T6_const", bif.rdata, 32'h11AA_8001);
`endif

        // T5: req held high through three loads
        @(negedge clk);
        a0 = acc_cnt;
        drive(1'b0, 2'b10, 1'b0, 32'h0010_0000, 32'h0);
        n = 0; dn = 0;
        while (dn < 3 && n < 40) begin
            @(posedge clk); #1; n++;
            if (bif.done) dn++;
        end
        bif.req = 1'b0;
        chk("T5_done_count", dn, 3);
        chk("T5_cycles", n, 8);
        exp_rdata = ref_load(2'b10, 1'b0, 10'h000);
        chk("T5_rdata", bif.rdata, exp_rdata);
        repeat (3) @(negedge clk);
        chk("T5_accepts", acc_cnt - a0, 3);

        for (int i = 0; i < 60; i++) begin
            ra = 32'h0010_0000 + 32'($urandom_range(0, 63));
            do_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), ra, $urandom);
        end
        for (int w = 0; w < 16; w++) chk($sformatf("mem_word%0d", w), dmem[w], ref_word(10'(w * 4)));
        chk("never_both_enables", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
